sim_probe_csr_trace: RTL and testbench
======================================

Name: sim_probe_csr_trace

Overview:
Parametrised CSR probe for the NPC simulation harness. Keeps shadow copies of a configurable set of CSRs, answers combinational address queries, and records every matched CSR write into a timestamped trace FIFO. A valid/ready drain port lets the C++ harness or a debug monitor consume the FIFO. Sits beside the CSR file and is driven by its write-port signals; it has no influence on core state.

Parameters:
XLEN, 32, CSR data width
NUM_CSR, 4, number of shadowed CSRs
CSR_ADDRS, {12'h342,12'h341,12'h305,12'h300}, packed NUM_CSR x 12-bit address list; entry i is bits [12*i+11:12*i]
DEPTH, 16, trace FIFO depth, power of two, >=2
TS_W, 32, timestamp width

Ports:
clock  in  1  core clock
reset_n  in  1  asynchronous active-low reset
wr_valid  in  1  CSR write event this cycle
wr_addr  in  12  CSR address of write
wr_data  in  XLEN  new CSR value
trace_en  in  1  enables FIFO capture
clr_ovf  in  1  clears overflow flag and count
q_addr  in  12  query address
q_data  out  XLEN  shadow value for q_addr
q_hit  out  1  q_addr matches a shadowed CSR
trc_valid  out  1  FIFO head valid
trc_ready  in  1  consumer accepts head
trc_addr  out  12  head: CSR address
trc_old  out  XLEN  head: value before write
trc_new  out  XLEN  head: value written
trc_ts  out  TS_W  head: timestamp of write
trc_count  out  $clog2(DEPTH)+1  entries held
ovf  out  1  sticky overflow flag
ovf_cnt  out  16  dropped-entry count, saturating

Behaviour:
- Reset (async assert, sync-released by harness): all shadows 0, FIFO empty, trc_valid=0, trc_count=0, timestamp 0, ovf=0, ovf_cnt=0; trc_addr/old/new/ts read 0 when empty.
- Timestamp: free-running TS_W counter, +1 every cycle after reset, wraps to 0 at all-ones.
- Match: wr_addr equals entry i of CSR_ADDRS; duplicate entries in the address list are illegal; lowest index wins if present.
- Shadow update: wr_valid && match -> shadow[i] <= wr_data on the edge; visible on q_data the next cycle. Non-matching writes are ignored entirely (no shadow change, no push).
- Query: purely combinational; q_hit=1 and q_data=shadow[i] on match, else q_hit=0, q_data=0.
- Push: wr_valid && match && trace_en -> entry {wr_addr, shadow[i] pre-write, wr_data, current timestamp}.
- FIFO is first-word-fall-through: trc_valid = (count!=0); head fields are driven from storage without a ready dependency.
- Pop: trc_valid && trc_ready on an edge.
- Full (count==DEPTH): push with simultaneous pop is accepted and count is unchanged. Push without pop is dropped, ovf<=1, ovf_cnt+1 saturating at 16'hFFFF.
- Empty: trc_ready ignored; a push into an empty FIFO makes trc_valid=1 the next cycle.
- clr_ovf: ovf<=0, ovf_cnt<=0. If a drop occurs in the same cycle, the clear wins.
- Pointers: log2(DEPTH)-bit, wrap naturally; count tracked separately.
- Reset mid-operation: FIFO contents discarded immediately and shadows zeroed; no partial entry survives.

Test Plan:
- Reset, then wr_valid, addr 0x305, data 0x80000000 -> next cycle q_addr=0x305 gives q_hit=1, q_data=0x80000000; FIFO entry {0x305, 0, 0x80000000, ts} with trc_valid=1.
- Write 0x300 twice (0x8, then 0x1888) with trc_ready=0 -> two entries, second has old=0x8; count=2; drain gives FIFO order with increasing ts.
- Write to 0x7C0 -> q_hit=0, no push, count unchanged.
- DEPTH+3 matched writes with trc_ready=0 -> count=16, ovf=1, ovf_cnt=3; then clr_ovf -> both 0.
- FIFO full, push and pop in the same cycle -> count stays 16, ovf stays 0, head advances.
- trace_en=0, write 0x341=0x100 -> shadow updated, no push; assert reset_n=0 with 5 entries queued -> trc_valid=0 and q_data=0 asynchronously.

Source files
------------

// File: rtl/sim_probe_csr_trace.sv
// CSR probe: shadows a set of CSRs, answers address queries combinationally,
// and logs matched CSR writes into a timestamped first-word-fall-through FIFO.
module sim_probe_csr_trace #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_CSR = 4,
    parameter logic [NUM_CSR*12-1:0] CSR_ADDRS = {12'h342, 12'h341, 12'h305, 12'h300},
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TS_W    = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_valid,
    input  logic [11:0]              wr_addr,
    input  logic [XLEN-1:0]          wr_data,
    input  logic                     trace_en,
    input  logic                     clr_ovf,
    input  logic [11:0]              q_addr,
    output logic [XLEN-1:0]          q_data,
    output logic                     q_hit,
    output logic                     trc_valid,
    input  logic                     trc_ready,
    output logic [11:0]              trc_addr,
    output logic [XLEN-1:0]          trc_old,
    output logic [XLEN-1:0]          trc_new,
    output logic [TS_W-1:0]          trc_ts,
    output logic [$clog2(DEPTH):0]   trc_count,
    output logic                     ovf,
    output logic [15:0]              ovf_cnt
);

    localparam int unsigned AW    = 12;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;

    logic [XLEN-1:0]  shadow [NUM_CSR];
    logic [AW-1:0]    mem_addr [DEPTH];
    logic [XLEN-1:0]  mem_old  [DEPTH];
    logic [XLEN-1:0]  mem_new  [DEPTH];
    logic [TS_W-1:0]  mem_ts   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TS_W-1:0]  ts;

    logic             wr_hit;
    logic [IDX_W-1:0] wr_idx;
    logic             q_match;
    logic [IDX_W-1:0] q_idx;
    logic             push_req;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             drop;

    // Address decode for the write port; scanning downward lets the lowest index win.
    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = NUM_CSR - 1; i >= 0; i--) begin
            if (wr_addr == CSR_ADDRS[AW*i +: AW]) begin
                wr_hit = 1'b1;
                wr_idx = IDX_W'(i);
            end
        end
    end

    // Address decode for the query port.
    always_comb begin
        q_match = 1'b0;
        q_idx   = '0;
        for (int i = NUM_CSR - 1; i >= 0; i--) begin
            if (q_addr == CSR_ADDRS[AW*i +: AW]) begin
                q_match = 1'b1;
                q_idx   = IDX_W'(i);
            end
        end
    end

    // FIFO handshake decisions; a full FIFO still accepts a push when the head leaves.
    always_comb begin
        push_req = wr_valid && wr_hit && trace_en;
        full     = (count == CNT_W'(DEPTH));
        do_pop   = trc_valid && trc_ready;
        do_push  = push_req && (!full || do_pop);
        drop     = push_req && full && !do_pop;
    end

    // Shadow registers follow every matched write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                shadow[i] <= '0;
            end
        end else if (wr_valid && wr_hit) begin
            shadow[wr_idx] <= wr_data;
        end
    end

    // Free-running timestamp.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TS_W'(1);
        end
    end

    // Entry storage; contents are only visible while count says they are live.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= wr_addr;
            mem_old[wr_ptr]  <= shadow[wr_idx];
            mem_new[wr_ptr]  <= wr_data;
            mem_ts[wr_ptr]   <= ts;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Sticky overflow and saturating drop counter; a clear beats a same-cycle drop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (clr_ovf) begin
            ovf     <= 1'b0;
            ovf_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != 16'hFFFF) begin
                ovf_cnt <= ovf_cnt + 16'd1;
            end
        end
    end

    // Output view: query result and head fields, zeroed when nothing is present.
    always_comb begin
        q_hit     = q_match;
        q_data    = q_match ? shadow[q_idx] : '0;
        trc_valid = (count != '0);
        trc_count = count;
        trc_addr  = trc_valid ? mem_addr[rd_ptr] : '0;
        trc_old   = trc_valid ? mem_old[rd_ptr]  : '0;
        trc_new   = trc_valid ? mem_new[rd_ptr]  : '0;
        trc_ts    = trc_valid ? mem_ts[rd_ptr]   : '0;
    end

endmodule

// File: tb/tb_sim_probe_csr_trace.sv
// Directed bench for sim_probe_csr_trace: vector table plus multi-cycle sequences.
module tb_sim_probe_csr_trace;

    logic        clock;
    logic        reset_n;
    logic        wr_valid;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        trace_en;
    logic        clr_ovf;
    logic [11:0] q_addr;
    logic [31:0] q_data;
    logic        q_hit;
    logic        trc_valid;
    logic        trc_ready;
    logic [11:0] trc_addr;
    logic [31:0] trc_old;
    logic [31:0] trc_new;
    logic [31:0] trc_ts;
    logic [4:0]  trc_count;
    logic        ovf;
    logic [15:0] ovf_cnt;

    int n_cmp;
    int n_err;
    int ticks;

    sim_probe_csr_trace dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .trace_en  (trace_en),
        .clr_ovf   (clr_ovf),
        .q_addr    (q_addr),
        .q_data    (q_data),
        .q_hit     (q_hit),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_addr  (trc_addr),
        .trc_old   (trc_old),
        .trc_new   (trc_new),
        .trc_ts    (trc_ts),
        .trc_count (trc_count),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        wv;
        logic [11:0] addr;
        logic [31:0] data;
        logic        ten;
        logic        rdy;
        logic [11:0] qa;
        logic        e_hit;
        logic [31:0] e_qd;
        logic [4:0]  e_cnt;
        logic        e_val;
        logic [11:0] e_ha;
        logic [31:0] e_ho;
        logic [31:0] e_hn;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        ticks++;
    endtask

    task automatic idle();
        wr_valid  = 1'b0;
        wr_addr   = 12'h000;
        wr_data   = 32'h0;
        trace_en  = 1'b1;
        clr_ovf   = 1'b0;
        trc_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        ticks   = 0;
    endtask

    task automatic drive_wr(input logic [11:0] a, input logic [31:0] d, input logic ten, input logic rdy);
        wr_valid  = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        trace_en  = ten;
        trc_ready = rdy;
    endtask

    initial begin
        int exp_ts0;
        int exp_ts1;
        n_cmp   = 0;
        n_err   = 0;
        ticks   = 0;
        q_addr  = 12'h305;
        reset_n = 1'b0;
        idle();

        //                wv    addr     data          ten   rdy   qa       hit   qd            cnt   val   ha       ho        hn
        vecs[0] = '{1'b1, 12'h305, 32'h8000_0000, 1'b1, 1'b0, 12'h305, 1'b1, 32'h8000_0000, 5'd1, 1'b1, 12'h305, 32'h0,    32'h8000_0000};
        vecs[1] = '{1'b1, 12'h300, 32'h0000_0008, 1'b1, 1'b0, 12'h300, 1'b1, 32'h0000_0008, 5'd2, 1'b1, 12'h305, 32'h0,    32'h8000_0000};
        vecs[2] = '{1'b1, 12'h300, 32'h0000_1888, 1'b1, 1'b0, 12'h300, 1'b1, 32'h0000_1888, 5'd3, 1'b1, 12'h305, 32'h0,    32'h8000_0000};
        vecs[3] = '{1'b1, 12'h7C0, 32'hDEAD_BEEF, 1'b1, 1'b0, 12'h7C0, 1'b0, 32'h0,         5'd3, 1'b1, 12'h305, 32'h0,    32'h8000_0000};
        vecs[4] = '{1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 12'h305, 1'b1, 32'h8000_0000, 5'd2, 1'b1, 12'h300, 32'h0,    32'h8};
        vecs[5] = '{1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 12'h300, 1'b1, 32'h0000_1888, 5'd1, 1'b1, 12'h300, 32'h8,    32'h1888};
        vecs[6] = '{1'b1, 12'h341, 32'h0000_0100, 1'b0, 1'b0, 12'h341, 1'b1, 32'h0000_0100, 5'd1, 1'b1, 12'h300, 32'h8,    32'h1888};
        vecs[7] = '{1'b1, 12'h342, 32'h0000_0005, 1'b1, 1'b1, 12'h342, 1'b1, 32'h0000_0005, 5'd1, 1'b1, 12'h342, 32'h0,    32'h5};
        vecs[8] = '{1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 12'h300, 1'b1, 32'h0000_1888, 5'd0, 1'b0, 12'h000, 32'h0,    32'h0};
        vecs[9] = '{1'b0, 12'h000, 32'h0,         1'b1, 1'b1, 12'h123, 1'b0, 32'h0,         5'd0, 1'b0, 12'h000, 32'h0,    32'h0};

        // Reset state
        do_reset();
        chk("rst_count", 64'(trc_count), 64'd0);
        chk("rst_valid", 64'(trc_valid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
        chk("rst_ts", 64'(trc_ts), 64'd0);
        chk("rst_q_hit", 64'(q_hit), 64'd1);
        chk("rst_q_data", 64'(q_data), 64'd0);

        // Vector table
        for (int v = 0; v < 10; v++) begin
            wr_valid  = vecs[v].wv;
            wr_addr   = vecs[v].addr;
            wr_data   = vecs[v].data;
            trace_en  = vecs[v].ten;
            trc_ready = vecs[v].rdy;
            q_addr    = vecs[v].qa;
            tick();
            chk($sformatf("v%0d_q_hit", v), 64'(q_hit), 64'(vecs[v].e_hit));
            chk($sformatf("v%0d_q_data", v), 64'(q_data), 64'(vecs[v].e_qd));
            chk($sformatf("v%0d_count", v), 64'(trc_count), 64'(vecs[v].e_cnt));
            chk($sformatf("v%0d_valid", v), 64'(trc_valid), 64'(vecs[v].e_val));
            chk($sformatf("v%0d_head_addr", v), 64'(trc_addr), 64'(vecs[v].e_ha));
            chk($sformatf("v%0d_head_old", v), 64'(trc_old), 64'(vecs[v].e_ho));
            chk($sformatf("v%0d_head_new", v), 64'(trc_new), 64'(vecs[v].e_hn));
        end
        idle();

        // Timestamps: two back-to-back writes after an idle gap
        do_reset();
        repeat (3) tick();
        exp_ts0 = ticks;
        drive_wr(12'h300, 32'h8, 1'b1, 1'b0);
        tick();
        exp_ts1 = ticks;
        drive_wr(12'h300, 32'h1888, 1'b1, 1'b0);
        tick();
        idle();
        chk("ts_count", 64'(trc_count), 64'd2);
        chk("ts_first", 64'(trc_ts), 64'(exp_ts0));
        chk("ts_first_old", 64'(trc_old), 64'h0);
        trc_ready = 1'b1;
        tick();
        trc_ready = 1'b0;
        chk("ts_second", 64'(trc_ts), 64'(exp_ts1));
        chk("ts_second_old", 64'(trc_old), 64'h8);
        chk("ts_second_new", 64'(trc_new), 64'h1888);

        // Overflow: DEPTH+3 writes without draining
        do_reset();
        for (int k = 0; k < 19; k++) begin
            drive_wr(12'h305, 32'(k), 1'b1, 1'b0);
            tick();
        end
        idle();
        chk("ovf_count", 64'(trc_count), 64'd16);
        chk("ovf_flag", 64'(ovf), 64'd1);
        chk("ovf_cnt", 64'(ovf_cnt), 64'd3);
        chk("ovf_head", 64'(trc_new), 64'd0);

        // Full FIFO with simultaneous push and pop
        drive_wr(12'h305, 32'h99, 1'b1, 1'b1);
        tick();
        idle();
        chk("full_pp_count", 64'(trc_count), 64'd16);
        chk("full_pp_ovf_cnt", 64'(ovf_cnt), 64'd3);
        chk("full_pp_head", 64'(trc_new), 64'd1);
        chk("full_pp_head_old", 64'(trc_old), 64'd0);

        // Clear alone, then clear racing a drop, then a lone drop
        clr_ovf = 1'b1;
        tick();
        chk("clr_ovf", 64'(ovf), 64'd0);
        chk("clr_ovf_cnt", 64'(ovf_cnt), 64'd0);
        drive_wr(12'h305, 32'hAA, 1'b1, 1'b0);
        clr_ovf = 1'b1;
        tick();
        chk("clr_wins_ovf", 64'(ovf), 64'd0);
        chk("clr_wins_cnt", 64'(ovf_cnt), 64'd0);
        clr_ovf = 1'b0;
        tick();
        idle();
        chk("drop_ovf", 64'(ovf), 64'd1);
        chk("drop_cnt", 64'(ovf_cnt), 64'd1);
        chk("drop_count", 64'(trc_count), 64'd16);

        // Drain in order: 1..15 then the entry pushed while full
        for (int k = 0; k < 16; k++) begin
            logic [31:0] e;
            e = (k < 15) ? 32'(k + 1) : 32'h99;
            chk($sformatf("drain%0d", k), 64'(trc_new), 64'(e));
            trc_ready = 1'b1;
            tick();
        end
        trc_ready = 1'b0;
        chk("drain_empty_valid", 64'(trc_valid), 64'd0);
        chk("drain_empty_count", 64'(trc_count), 64'd0);

        // Reset with entries queued
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive_wr(12'h341, 32'(k * 32'h11), 1'b1, 1'b0);
            tick();
        end
        idle();
        q_addr = 12'h341;
        #1;
        chk("pre_rst_count", 64'(trc_count), 64'd5);
        chk("pre_rst_q_data", 64'(q_data), 64'h55);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(trc_valid), 64'd0);
        chk("async_rst_count", 64'(trc_count), 64'd0);
        chk("async_rst_q_data", 64'(q_data), 64'd0);
        chk("async_rst_head_new", 64'(trc_new), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_valid", 64'(trc_valid), 64'd0);
        chk("post_rst_q_hit", 64'(q_hit), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
